srf02_i2c_target: RTL

I2C target (responder) that emulates the SRF02 ultrasonic ranger on the board-level I2C bus. It answers the transactions our I2C read/write controllers issue: address write, register-pointer write, repeated start, and multi-byte range read. It runs in-fabric for hardware-in-the-loop bring-up and simulation. Range values come from a parallel load port. Written commands are handed to local logic as strobes.

---
 rtl/srf02_i2c_target.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/srf02_i2c_target.sv
// I2C target emulating the SRF02 ultrasonic ranger: pointer write, command write, shadowed multi-byte read.
// Build option: define SRF02_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter after each synchronizer.
module srf02_i2c_target #(
  parameter logic [6:0] ADDR7       = 7'h70,
  parameter logic [7:0] SW_REV      = 8'h06,
  parameter logic [7:0] AUTOTUNE_LO = 8'h12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] range_data,
  input  logic        range_load,
  output logic [7:0]  cmd,
  output logic        cmd_valid,
  output logic        busy,
  output logic        addressed
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
  } state_t;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_c, sda_c, scl_prev_q, sda_prev_q;

  // Synchronizers preset high so reset never fabricates a bus edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
    end
  end

`ifdef SRF02_TARGET_GLITCH_FILTER_EN
  logic [2:0] scl_hist_q, sda_hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
    end else begin
      scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
    end
  end

  assign scl_c = (scl_hist_q[0] & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[2]) | (scl_hist_q[1] & scl_hist_q[2]);
  assign sda_c = (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[2]) | (sda_hist_q[1] & sda_hist_q[2]);
`else
  assign scl_c = scl_sync_q[1];
  assign sda_c = sda_sync_q[1];
`endif

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_c & ~scl_prev_q;
  assign scl_fall  = ~scl_c & scl_prev_q;
  assign start_det = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
  assign stop_det  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;

  state_t          state_q, state_d;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shreg_q, shreg_d, txsh_q, txsh_d, cmd_q, cmd_d;
  logic [2:0]      ptr_q, ptr_d;
  logic            rw_q, rw_d, sda_oe_q, sda_oe_d, cmd_valid_q, cmd_valid_d;
  logic            busy_q, busy_d, addressed_q, addressed_d;
  logic [15:0]     range_q, range_d;
  logic [7:0][7:0] shadow_q, shadow_d, regmap;
  logic [7:0]      byte_in;

  assign byte_in = {shreg_q[6:0], sda_c};

  always_comb begin
    regmap    = '1;
    regmap[0] = busy_q ? 8'hFF : SW_REV;
    regmap[1] = 8'h80;
    regmap[2] = range_q[15:8];
    regmap[3] = range_q[7:0];
    regmap[4] = 8'h00;
    regmap[5] = AUTOTUNE_LO;
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    txsh_d      = txsh_q;
    cmd_d       = cmd_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    cmd_valid_d = 1'b0;
    busy_d      = busy_q;
    addressed_d = addressed_q;
    range_d     = range_q;
    shadow_d    = shadow_q;

    if (start_det) begin
      state_d     = ADDR;
      bitcnt_d    = '0;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
    end else if (stop_det) begin
      state_d     = IDLE;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shreg_d  = byte_in;
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall && bitcnt_q == 4'd8) begin
            bitcnt_d = '0;
            if (shreg_q[7:1] == ADDR7) begin
              state_d     = ADDR_ACK;
              sda_oe_d    = 1'b1;
              addressed_d = 1'b1;
              rw_d        = shreg_q[0];
              if (shreg_q[0]) shadow_d = regmap;
            end else begin
              state_d = IDLE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              state_d  = RDATA;
              txsh_d   = shadow_q[ptr_q];
              sda_oe_d = ~shadow_q[ptr_q][7];
            end else begin
              state_d  = REG;
              sda_oe_d = 1'b0;
            end
          end
        end
        REG: begin
          if (scl_rise) begin
            shreg_d  = byte_in;
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall && bitcnt_q == 4'd8) begin
            ptr_d    = shreg_q[2:0];
            sda_oe_d = 1'b1;
            bitcnt_d = '0;
            state_d  = REG_ACK;
          end
        end
        REG_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = WDATA;
          end
        end
        WDATA: begin
          if (scl_rise) begin
            shreg_d  = byte_in;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7 && ptr_q == 3'd0) begin
              cmd_d       = byte_in;
              cmd_valid_d = 1'b1;
              if (byte_in >= 8'h50 && byte_in <= 8'h56) busy_d = 1'b1;
            end
          end else if (scl_fall && bitcnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            ptr_d    = ptr_q + 3'd1;
            bitcnt_d = '0;
            state_d  = WDATA_ACK;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bitcnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              bitcnt_d = '0;
              state_d  = RACK;
            end else begin
              txsh_d   = txsh_q << 1;
              sda_oe_d = ~txsh_q[6];
            end
          end
        end
        RACK: begin
          // bitcnt doubles as the "master ACKed" marker between the 9th rise and fall.
          if (scl_rise) begin
            ptr_d = ptr_q + 3'd1;
            if (sda_c) state_d = IGNORE;
            else       bitcnt_d = 4'd1;
          end else if (scl_fall && bitcnt_q == 4'd1) begin
            state_d  = RDATA;
            txsh_d   = shadow_q[ptr_q];
            sda_oe_d = ~shadow_q[ptr_q][7];
            bitcnt_d = '0;
          end
        end
        default: ;
      endcase
    end

    if (range_load) begin
      range_d = range_data;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      txsh_q      <= '0;
      cmd_q       <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      addressed_q <= 1'b0;
      range_q     <= '0;
      shadow_q    <= '0;
    end else begin
      scl_prev_q  <= scl_c;
      sda_prev_q  <= sda_c;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      txsh_q      <= txsh_d;
      cmd_q       <= cmd_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
      addressed_q <= addressed_d;
      range_q     <= range_d;
      shadow_q    <= shadow_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign busy      = busy_q;
  assign addressed = addressed_q;

endmodule
